poly_eval_mem: RTL and testbench

//  Parametrised polynomial evaluation memory. On a write request it evaluates P(x) or P'(x)

---
 rtl/poly_eval_mem_if.sv | 31 +++
 rtl/poly_eval_mem.sv | 131 +++++++++++++
 tb/tb_poly_eval_mem.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/poly_eval_mem_if.sv
// Request/response bundle for poly_eval_mem.
// Handshake: start is a one-cycle request that is accepted only while busy is low; done/outValid are one-cycle completion pulses.
interface poly_eval_mem_if #(
    parameter int ADDR_W = 4,
    parameter int DEG    = 4,
    parameter int COEF_W = 1,
    parameter int ARG_W  = 3,
    parameter int OUT_W  = 16
);
    logic                      start;
    logic                      mode;
    logic [ADDR_W-1:0]         addr;
    logic                      op;
    logic [ARG_W-1:0]          arg;
    logic [(DEG+1)*COEF_W-1:0] coefIn;
    logic                      busy;
    logic                      done;
    logic                      outValid;
    logic [OUT_W-1:0]          memOutput;
    logic                      ovf;

    modport master (
        output start, mode, addr, op, arg, coefIn,
        input  busy, done, outValid, memOutput, ovf
    );

    modport slave (
        input  start, mode, addr, op, arg, coefIn,
        output busy, done, outValid, memOutput, ovf
    );
endinterface

// File: rtl/poly_eval_mem.sv
// Horner evaluator of P(x) or P'(x), one term per cycle, storing the result and a
// sticky overflow flag in a small RAM that is read back through the same bus.
module poly_eval_mem #(
    parameter  int DEPTH  = 16,
    parameter  int DEG    = 4,
    parameter  int COEF_W = 1,
    parameter  int ARG_W  = 3,
    parameter  int OUT_W  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    poly_eval_mem_if.slave    bus,
    output logic [1:0]        stateDbg
);
    localparam int KW = $clog2(DEG + 2);
    localparam int TW = KW + COEF_W;
    localparam int FW = OUT_W + ARG_W + COEF_W + KW + 2;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, WRITE = 2'd2} state_t;

    state_t                    state, stateNext;
    logic [KW-1:0]             k;
    logic [OUT_W-1:0]          acc;
    logic                      accOvf;
    logic [ADDR_W-1:0]         addrLat;
    logic                      opLat;
    logic [ARG_W-1:0]          argLat;
    logic [(DEG+1)*COEF_W-1:0] coefLat;
    logic [OUT_W-1:0]          ram  [DEPTH];
    logic                      flag [DEPTH];

    logic writeStart, readStart, calcStep, ramWrite, lastIter;

    logic [COEF_W-1:0]     coefSel;
    logic [KW-1:0]         kSel;
    logic [TW-1:0]         termU;
    logic signed [FW-1:0]  accExt, argExt, termExt, step;
    logic                  stepOvf;

    assign coefSel  = coefLat[k*COEF_W +: COEF_W];
    assign kSel     = opLat ? k : KW'(1);
    assign termU    = {{COEF_W{1'b0}}, kSel} * {{KW{1'b0}}, coefSel};
    assign accExt   = {{(FW-OUT_W){acc[OUT_W-1]}}, acc};
    assign argExt   = {{(FW-ARG_W){argLat[ARG_W-1]}}, argLat};
    assign termExt  = {{(FW-TW){1'b0}}, termU};
    assign step     = accExt * argExt + termExt;
    // Overflow means the full-precision step does not survive truncation to OUT_W bits.
    assign stepOvf  = (step != {{(FW-OUT_W){step[OUT_W-1]}}, step[OUT_W-1:0]});
    assign lastIter = opLat ? (k == KW'(1)) : (k == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        writeStart = 1'b0;
        readStart  = 1'b0;
        calcStep   = 1'b0;
        ramWrite   = 1'b0;
        bus.busy   = (state != IDLE);
        case (state)
            IDLE: begin
                if (bus.start && bus.mode) begin
                    writeStart = 1'b1;
                    stateNext  = (bus.op && DEG == 0) ? WRITE : CALC;
                end else if (bus.start) begin
                    readStart = 1'b1;
                end
            end
            CALC: begin
                calcStep = 1'b1;
                if (lastIter) stateNext = WRITE;
            end
            WRITE: begin
                ramWrite  = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            k             <= '0;
            acc           <= '0;
            accOvf        <= 1'b0;
            addrLat       <= '0;
            opLat         <= 1'b0;
            argLat        <= '0;
            coefLat       <= '0;
            bus.done      <= 1'b0;
            bus.outValid  <= 1'b0;
            bus.memOutput <= '0;
            bus.ovf       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ram[i]  <= '0;
                flag[i] <= 1'b0;
            end
        end else begin
            bus.done     <= ramWrite;
            bus.outValid <= readStart;
            if (writeStart) begin
                addrLat <= bus.addr;
                opLat   <= bus.op;
                argLat  <= bus.arg;
                coefLat <= bus.coefIn;
                acc     <= '0;
                accOvf  <= 1'b0;
                k       <= KW'(DEG);
            end
            if (calcStep) begin
                acc <= step[OUT_W-1:0];
                k   <= k - KW'(1);
                if (stepOvf) accOvf <= 1'b1;
            end
            if (ramWrite) begin
                ram[addrLat]  <= acc;
                flag[addrLat] <= accOvf;
            end
            if (readStart) begin
                bus.memOutput <= ram[bus.addr];
                bus.ovf       <= flag[bus.addr];
            end
        end
    end

    assign stateDbg = state;
endmodule

// File: tb/tb_poly_eval_mem.sv
// Self-checking bench for poly_eval_mem: a 16-bit and a 4-bit result instance
// against a Horner reference model computed with longint arithmetic.
module tb_poly_eval_mem;
  localparam int DEG = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [1:0] state_dbg_a, state_dbg_b;

  poly_eval_mem_if #(.ADDR_W(4), .DEG(4), .COEF_W(1), .ARG_W(3), .OUT_W(16)) if_a ();
  poly_eval_mem_if #(.ADDR_W(4), .DEG(4), .COEF_W(1), .ARG_W(3), .OUT_W(4))  if_b ();

  poly_eval_mem #(.DEPTH(16), .DEG(4), .COEF_W(1), .ARG_W(3), .OUT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .bus(if_a.slave), .stateDbg(state_dbg_a));
  poly_eval_mem #(.DEPTH(16), .DEG(4), .COEF_W(1), .ARG_W(3), .OUT_W(4)) dut_b (
    .CLK(CLK), .RST(RST), .bus(if_b.slave), .stateDbg(state_dbg_b));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  logic [15:0] exp_val[2][16];
  bit          exp_ovf[2][16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int out_w(input bit sel);
    return sel ? 4 : 16;
  endfunction

  function automatic void model(input logic [4:0] c, input logic [2:0] xa, input bit o,
                                input int w, output logic [15:0] v, output bit ov);
    longint acc, full, x, t, hi, lo, m;
    acc = 0; ov = 0;
    x  = longint'($signed(xa));
    m  = longint'(1) << w;
    hi = m / 2 - 1;
    lo = -(m / 2);
    for (int k = DEG; k >= (o ? 1 : 0); k--) begin
      t    = longint'(c[k]) * (o ? longint'(k) : longint'(1));
      full = acc * x + t;
      if (full > hi || full < lo) ov = 1;
      acc = full % m;
      if (acc < 0)  acc += m;
      if (acc > hi) acc -= m;
    end
    v = 16'(acc & (m - 1));
  endfunction

  task automatic set_req(input bit sel, input bit s, input bit m, input logic [3:0] a,
                         input bit o, input logic [2:0] x, input logic [4:0] c);
    if (!sel) begin
      if_a.start = s; if_a.mode = m; if_a.addr = a; if_a.op = o; if_a.arg = x; if_a.coefIn = c;
    end else begin
      if_b.start = s; if_b.mode = m; if_b.addr = a; if_b.op = o; if_b.arg = x; if_b.coefIn = c;
    end
  endtask

  // {busy, done, outValid, ovf}
  function automatic logic [3:0] flags(input bit sel);
    return sel ? {if_b.busy, if_b.done, if_b.outValid, if_b.ovf}
               : {if_a.busy, if_a.done, if_a.outValid, if_a.ovf};
  endfunction

  function automatic logic [15:0] mem_out(input bit sel);
    return sel ? {12'b0, if_b.memOutput} : if_a.memOutput;
  endfunction

  task automatic scramble(input bit sel);
    set_req(sel, 1'b0, 1'($urandom), 4'($urandom), 1'($urandom), 3'($urandom), 5'($urandom));
  endtask

  task automatic do_write(input bit sel, input logic [3:0] a, input bit o, input logic [2:0] x,
                          input logic [4:0] c, input bit disturb);
    logic [15:0] v;
    bit ov, saw_ov;
    int got, lat;
    model(c, x, o, out_w(sel), v, ov);
    lat = o ? DEG + 1 : DEG + 2;
    got = 0; saw_ov = 0;
    @(negedge CLK); set_req(sel, 1'b1, 1'b1, a, o, x, c);
    @(posedge CLK); #1; scramble(sel);
    check("busy_after_start", 32'(flags(sel)[3]), 32'd1);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge CLK); #1;
      if (flags(sel)[1]) saw_ov = 1;
      if (flags(sel)[2]) begin got = cyc; break; end
      if (disturb && cyc == 2)
        set_req(sel, 1'b1, 1'($urandom), a ^ 4'h1, ~o, 3'($urandom), 5'($urandom));
      if (disturb && cyc == 3) scramble(sel);
    end
    check("write_latency", 32'(got), 32'(lat));
    check("busy_low_at_done", 32'(flags(sel)[3]), 32'd0);
    check("no_outvalid_in_write", 32'(saw_ov), 32'd0);
    @(posedge CLK); #1;
    check("done_one_pulse", 32'(flags(sel)[2]), 32'd0);
    exp_val[sel][a] = v;
    exp_ovf[sel][a] = ov;
  endtask

  task automatic do_read(input bit sel, input logic [3:0] a);
    logic [16:0] e;
    logic [15:0] held;
    exp_q.push_back({exp_ovf[sel][a], exp_val[sel][a]});
    @(negedge CLK); set_req(sel, 1'b1, 1'b0, a, 1'($urandom), 3'($urandom), 5'($urandom));
    @(posedge CLK); #1; scramble(sel);
    check("read_outvalid", 32'(flags(sel)[1]), 32'd1);
    check("read_no_done", 32'(flags(sel)[2]), 32'd0);
    e = exp_q.pop_front();
    check("read_value", 32'(mem_out(sel)), 32'(e[15:0]));
    check("read_ovf", 32'(flags(sel)[0]), 32'(e[16]));
    held = mem_out(sel);
    @(posedge CLK); #1;
    check("outvalid_one_pulse", 32'(flags(sel)[1]), 32'd0);
    check("read_value_held", 32'(mem_out(sel)), 32'(held));
  endtask

  task automatic check_outputs_zero(input bit sel, input string tag);
    check(tag, {12'b0, flags(sel)}, 32'd0);
    check(tag, 32'(mem_out(sel)), 32'd0);
  endtask

  initial begin
    set_req(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 5'd0);
    set_req(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 5'd0);
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++) begin exp_val[s][i] = '0; exp_ovf[s][i] = 0; end

    #2;
    check_outputs_zero(1'b0, "reset_a");
    check_outputs_zero(1'b1, "reset_b");
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;

    // Directed points with known answers.
    do_write(1'b0, 4'd3, 1'b0, 3'd2, 5'b00111, 1'b0);
    do_read(1'b0, 4'd3);
    check("poly_x2", 32'(mem_out(1'b0)), 32'd7);
    do_write(1'b0, 4'd4, 1'b1, 3'd2, 5'b00111, 1'b0);
    do_read(1'b0, 4'd4);
    check("deriv_x2", 32'(mem_out(1'b0)), 32'd5);
    do_write(1'b0, 4'd8, 1'b0, 3'b111, 5'b11111, 1'b0);
    do_read(1'b0, 4'd8);
    check("poly_xm1", 32'(mem_out(1'b0)), 32'd1);
    do_write(1'b0, 4'd9, 1'b1, 3'b111, 5'b11111, 1'b0);
    do_read(1'b0, 4'd9);
    check("deriv_xm1", 32'(mem_out(1'b0)), 32'h0000_FFFE);
    check("deriv_xm1_ovf", 32'(flags(1'b0)[0]), 32'd0);
    do_write(1'b1, 4'd2, 1'b0, 3'd3, 5'b11111, 1'b0);
    do_read(1'b1, 4'd2);
    check("narrow_wrap", 32'(mem_out(1'b1)), 32'd9);
    check("narrow_ovf", 32'(flags(1'b1)[0]), 32'd1);
    do_read(1'b0, 4'd15);

    // Requests during busy must be ignored, latched inputs immune to changes.
    do_write(1'b0, 4'd6, 1'b0, 3'($urandom), 5'($urandom), 1'b1);
    do_read(1'b0, 4'd6);
    do_read(1'b0, 4'd7);
    do_write(1'b0, 4'd3, 1'b1, 3'd3, 5'b11010, 1'b0);
    do_read(1'b0, 4'd3);

    for (int n = 0; n < 24; n++) begin
      bit sel;
      sel = 1'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_write(sel, 4'($urandom), 1'($urandom), 3'($urandom), 5'($urandom), 1'($urandom));
      else
        do_read(sel, 4'($urandom));
    end

    // Reset in the middle of an evaluation aborts it and clears the RAM.
    do_write(1'b0, 4'd5, 1'b0, 3'd2, 5'b00111, 1'b0);
    @(negedge CLK); set_req(1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 3'd3, 5'b10101);
    @(posedge CLK); #1; scramble(1'b0);
    repeat (2) @(posedge CLK);
    #3; RST = 1'b1;
    #1;
    check("reset_busy_drop", 32'(flags(1'b0)[3]), 32'd0);
    check_outputs_zero(1'b0, "midreset_a");
    check_outputs_zero(1'b1, "midreset_b");
    @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++) begin exp_val[s][i] = '0; exp_ovf[s][i] = 0; end
    do_read(1'b0, 4'd5);
    check("read_after_reset", 32'(mem_out(1'b0)), 32'd0);
    do_read(1'b0, 4'd3);
    do_read(1'b1, 4'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
